// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, oversampling constants and FSM state encodings.
// Pure declarations; no logic, so no latency or backpressure of its own.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] OS_MID  = 4'(OVERSAMPLE / 2 - 1);

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is visible combinationally, push/pop take effect next edge.
// Push when full (without a pop) and pop when empty are ignored; rd+wr on a full FIFO does both.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || rd);
    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (!do_wr && do_rd) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART with 16x oversampled RX/TX engines and a FWFT FIFO on each side; TX starts on the tick after a pop.
// RX byte lands one cycle after its final stop sample and is dropped (overrun) if the RX FIFO is full and not read.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          tx,
    input  logic [15:0]                   baud_div,
    input  logic                          rx_rd,
    output logic [DATA_BITS-1:0]          rx_rdata,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    input  logic                          tx_wr,
    input  logic [DATA_BITS-1:0]          tx_wdata,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          tx_busy,
    output logic                          err_frame,
    output logic                          err_parity,
    output logic                          err_overrun,
    input  logic                          err_clr
);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic       PAR_EN   = (PARITY != PAR_NONE);
    localparam logic       PAR_INV  = (PARITY == PAR_ODD);
    localparam logic       TWO_STOP = (STOP_BITS == 2);

    logic [15:0]          tick_cnt;
    logic [15:0]          div_q;
    logic                 tick;

    tx_state_t            tx_state;
    logic [3:0]           tx_os;
    logic [2:0]           tx_bit;
    logic                 tx_stop;
    logic                 tx_pend;
    logic                 tx_par;
    logic [DATA_BITS-1:0] tx_sh;
    logic [DATA_BITS-1:0] txf_rdata;
    logic                 txf_empty;
    logic                 tx_done;
    logic                 tx_pop;

    rx_state_t            rx_state;
    logic                 rx_m;
    logic                 rx_s;
    logic [3:0]           rx_os;
    logic [2:0]           rx_bit;
    logic                 rx_stop;
    logic                 rx_bad;
    logic                 rx_push;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rxf_full;

    // Divisor is latched only at wrap so a change never produces a short tick period.
    assign tick = (tick_cnt == div_q);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
            div_q    <= baud_div;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .wr(tx_wr), .wdata(tx_wdata), .rd(tx_pop),
        .rdata(txf_rdata), .empty(txf_empty), .full(tx_full), .count(tx_count)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .wr(rx_push), .wdata(rx_sh), .rd(rx_rd),
        .rdata(rx_rdata), .empty(rx_empty), .full(rxf_full), .count(rx_count)
    );

    assign tx_done = (tx_state == TX_STOP) && tick && (tx_os == OS_LAST) && (!TWO_STOP || tx_stop);
    assign tx_pop  = !txf_empty && (((tx_state == TX_IDLE) && !tx_pend) || tx_done);
    assign tx_busy = (tx_state != TX_IDLE) || tx_pend || !txf_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_os    <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_pend  <= 1'b0;
            tx_par   <= 1'b0;
            tx_sh    <= '0;
        end else begin
            if (tx_pop) begin
                tx_sh  <= txf_rdata;
                tx_par <= (^txf_rdata) ^ PAR_INV;
            end
            if (tx_state == TX_IDLE) begin
                if (tx_pop) begin
                    tx_pend <= 1'b1;
                end else if (tx_pend && tick) begin
                    tx_pend  <= 1'b0;
                    tx       <= 1'b0;
                    tx_os    <= '0;
                    tx_state <= TX_START;
                end
            end else if (tick) begin
                tx_os <= tx_os + 4'd1;
                if (tx_os == OS_LAST) begin
                    case (tx_state)
                        TX_START: begin
                            tx_state <= TX_DATA;
                            tx       <= tx_sh[0];
                            tx_bit   <= '0;
                        end
                        TX_DATA: begin
                            if (tx_bit != BIT_LAST) begin
                                tx_bit <= tx_bit + 3'd1;
                                tx_sh  <= tx_sh >> 1;
                                tx     <= tx_sh[1];
                            end else if (PAR_EN) begin
                                tx_state <= TX_PARITY;
                                tx       <= tx_par;
                            end else begin
                                tx_state <= TX_STOP;
                                tx       <= 1'b1;
                                tx_stop  <= 1'b0;
                            end
                        end
                        TX_PARITY: begin
                            tx_state <= TX_STOP;
                            tx       <= 1'b1;
                            tx_stop  <= 1'b0;
                        end
                        TX_STOP: begin
                            if (!tx_done) begin
                                tx_stop <= 1'b1;
                            end else if (tx_pop) begin
                                tx_state <= TX_START;
                                tx       <= 1'b0;
                            end else begin
                                tx_state <= TX_IDLE;
                            end
                        end
                        default: tx_state <= TX_IDLE;
                    endcase
                end
            end
        end
    end

    // Error clears come first so any set later in this block takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_os       <= '0;
            rx_bit      <= '0;
            rx_stop     <= 1'b0;
            rx_bad      <= 1'b0;
            rx_push     <= 1'b0;
            rx_sh       <= '0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_push <= 1'b0;
            if (err_clr) begin
                err_frame   <= 1'b0;
                err_parity  <= 1'b0;
                err_overrun <= 1'b0;
            end
            if (rx_push && rxf_full && !rx_rd) err_overrun <= 1'b1;
            if (rx_state == RX_IDLE) begin
                if (!rx_s) begin
                    rx_state <= RX_START;
                    rx_os    <= '0;
                end
            end else if (tick) begin
                rx_os <= rx_os + 4'd1;
                case (rx_state)
                    RX_START: begin
                        if (rx_os == OS_MID) begin
                            rx_os    <= '0;
                            rx_bit   <= '0;
                            rx_bad   <= 1'b0;
                            rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (rx_os == OS_LAST) begin
                            rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                            if (rx_bit != BIT_LAST) begin
                                rx_bit <= rx_bit + 3'd1;
                            end else begin
                                rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
                                rx_stop  <= 1'b0;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (rx_os == OS_LAST) begin
                            if (rx_s != ((^rx_sh) ^ PAR_INV)) err_parity <= 1'b1;
                            rx_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (rx_os == OS_LAST) begin
                            if (!rx_s) err_frame <= 1'b1;
                            if (!TWO_STOP || rx_stop) begin
                                rx_state <= RX_IDLE;
                                rx_push  <= rx_s && !rx_bad;
                            end else begin
                                rx_stop <= 1'b1;
                                rx_bad  <= !rx_s;
                            end
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench: dut_a (no parity, 4-deep FIFOs) covers TX timing, loopback, framing, overrun and reset;
// dut_b (even parity) covers parity error detection and clearing.
module tb_uart_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        err_clr;
    logic        loop_en;
    logic [15:0] baud_div;

    logic        rx_drv, rx_a, tx_a, rx_rd_a, tx_wr_a;
    logic [7:0]  rx_rdata_a, tx_wdata_a;
    logic        rx_empty_a, tx_full_a, tx_busy_a;
    logic [2:0]  rx_count_a, tx_count_a;
    logic        err_frame_a, err_parity_a, err_overrun_a;

    logic        rx_b, tx_b, rx_rd_b, tx_wr_b;
    logic [7:0]  rx_rdata_b, tx_wdata_b;
    logic        rx_empty_b, tx_full_b, tx_busy_b;
    logic [4:0]  rx_count_b, tx_count_b;
    logic        err_frame_b, err_parity_b, err_overrun_b;

    int          checks = 0;
    int          errors = 0;
    logic        seen;
    logic [7:0]  pat;
    logic [7:0]  rx_bytes [5];

    assign rx_a = loop_en ? tx_a : rx_drv;

    uart_fifo_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .baud_div(baud_div),
        .rx_rd(rx_rd_a), .rx_rdata(rx_rdata_a), .rx_empty(rx_empty_a), .rx_count(rx_count_a),
        .tx_wr(tx_wr_a), .tx_wdata(tx_wdata_a), .tx_full(tx_full_a), .tx_count(tx_count_a),
        .tx_busy(tx_busy_a), .err_frame(err_frame_a), .err_parity(err_parity_a),
        .err_overrun(err_overrun_a), .err_clr(err_clr)
    );

    uart_fifo_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b), .baud_div(baud_div),
        .rx_rd(rx_rd_b), .rx_rdata(rx_rdata_b), .rx_empty(rx_empty_b), .rx_count(rx_count_b),
        .tx_wr(tx_wr_b), .tx_wdata(tx_wdata_b), .tx_full(tx_full_b), .tx_count(tx_count_b),
        .tx_busy(tx_busy_b), .err_frame(err_frame_b), .err_parity(err_parity_b),
        .err_overrun(err_overrun_b), .err_clr(err_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic to_b, input logic v, input int len);
        if (to_b) rx_b = v;
        else      rx_drv = v;
        repeat (len) @(negedge clk);
    endtask

    // 64 clocks per bit at baud_div=3; a bad stop is held low just past its mid-point.
    task automatic send_frame(input logic to_b, input logic [7:0] d, input logic with_par,
                              input logic par, input logic stop_ok);
        drive_bit(to_b, 1'b0, 64);
        for (int i = 0; i < 8; i++) drive_bit(to_b, d[i], 64);
        if (with_par) drive_bit(to_b, par, 64);
        if (stop_ok) begin
            drive_bit(to_b, 1'b1, 64);
        end else begin
            drive_bit(to_b, 1'b0, 44);
            drive_bit(to_b, 1'b1, 64);
        end
        drive_bit(to_b, 1'b1, 16);
    endtask

    task automatic push_a(input logic [7:0] d);
        tx_wdata_a = d;
        tx_wr_a    = 1'b1;
        @(negedge clk);
        tx_wr_a    = 1'b0;
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        check_eq(tag, 32'(rx_rdata_a), 32'(exp));
        rx_rd_a = 1'b1;
        @(negedge clk);
        rx_rd_a = 1'b0;
    endtask

    task automatic wait_tx_low(output logic found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (tx_a == 1'b0) found = 1'b1;
        end
    endtask

    task automatic wait_tx_idle(input int limit);
        for (int i = 0; i < limit && tx_busy_a; i++) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0; loop_en = 1'b0; baud_div = 16'd3;
        rx_drv = 1'b1; rx_rd_a = 1'b0; tx_wr_a = 1'b0; tx_wdata_a = 8'h00;
        rx_b = 1'b1; rx_rd_b = 1'b0; tx_wr_b = 1'b0; tx_wdata_b = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_tx_a", 32'(tx_a), 32'd1);
        check_eq("rst_rx_empty_a", 32'(rx_empty_a), 32'd1);
        check_eq("rst_rx_count_a", 32'(rx_count_a), 32'd0);
        check_eq("rst_tx_count_a", 32'(tx_count_a), 32'd0);
        check_eq("rst_tx_full_a", 32'(tx_full_a), 32'd0);
        check_eq("rst_tx_busy_a", 32'(tx_busy_a), 32'd0);
        check_eq("rst_rx_rdata_a", 32'(rx_rdata_a), 32'd0);
        check_eq("rst_errs_a", 32'({err_frame_a, err_parity_a, err_overrun_a}), 32'd0);
        check_eq("rst_tx_b", 32'(tx_b), 32'd1);
        check_eq("rst_fifo_b", 32'({rx_empty_b, tx_full_b, tx_busy_b}), 32'b100);
        check_eq("rst_counts_b", 32'({rx_count_b, tx_count_b}), 32'd0);
        check_eq("rst_errs_b", 32'({err_frame_b, err_parity_b, err_overrun_b}), 32'd0);

        // TX waveform of 0xA5: start 64 clocks low, then LSB-first bits, then stop
        push_a(8'hA5);
        check_eq("busy_after_wr", 32'(tx_busy_a), 32'd1);
        wait_tx_low(seen);
        check_eq("tx_start_seen", 32'(seen), 32'd1);
        repeat (63) @(negedge clk);
        check_eq("start_last_clk", 32'(tx_a), 32'd0);
        @(negedge clk);
        check_eq("bit0_first_clk", 32'(tx_a), 32'd1);
        pat = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            repeat (k == 0 ? 32 : 64) @(negedge clk);
            check_eq($sformatf("tx_bit%0d", k), 32'(tx_a), 32'(pat[k]));
        end
        repeat (64) @(negedge clk);
        check_eq("tx_stop", 32'(tx_a), 32'd1);
        wait_tx_idle(200);
        check_eq("tx_idle_after_frame", 32'(tx_busy_a), 32'd0);

        // loopback of three bytes through both FIFOs
        loop_en = 1'b1;
        push_a(8'h00);
        push_a(8'hFF);
        push_a(8'h3C);
        wait_tx_idle(3000);
        check_eq("loop_tx_drained", 32'(tx_busy_a), 32'd0);
        repeat (100) @(negedge clk);
        loop_en = 1'b0;
        check_eq("loop_rx_count", 32'(rx_count_a), 32'd3);
        check_eq("loop_errs", 32'({err_frame_a, err_parity_a, err_overrun_a}), 32'd0);
        pop_a("loop_pop0", 8'h00);
        pop_a("loop_pop1", 8'hFF);
        pop_a("loop_pop2", 8'h3C);
        check_eq("loop_empty", 32'(rx_empty_a), 32'd1);

        // frame with stop bit low is flagged and discarded
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("frame_err_set", 32'(err_frame_a), 32'd1);
        check_eq("frame_err_count", 32'(rx_count_a), 32'd0);
        check_eq("frame_err_empty", 32'(rx_empty_a), 32'd1);
        pulse_clr();
        check_eq("frame_err_clr", 32'(err_frame_a), 32'd0);

        // overrun: fifth byte into a full 4-deep FIFO is dropped
        rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
        rx_bytes[3] = 8'h44; rx_bytes[4] = 8'h55;
        for (int i = 0; i < 4; i++) send_frame(1'b0, rx_bytes[i], 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("ovr_count_full", 32'(rx_count_a), 32'd4);
        check_eq("ovr_not_yet", 32'(err_overrun_a), 32'd0);
        send_frame(1'b0, rx_bytes[4], 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("ovr_count_held", 32'(rx_count_a), 32'd4);
        check_eq("ovr_flag", 32'(err_overrun_a), 32'd1);
        for (int i = 0; i < 4; i++) pop_a($sformatf("ovr_pop%0d", i), rx_bytes[i]);
        check_eq("ovr_drained", 32'(rx_empty_a), 32'd1);

        // even parity: 0x07 needs parity 1; send 0 and expect the byte kept with an error
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("par_count", 32'(rx_count_b), 32'd1);
        check_eq("par_rdata", 32'(rx_rdata_b), 32'h07);
        check_eq("par_err_set", 32'(err_parity_b), 32'd1);
        check_eq("par_no_frame_err", 32'(err_frame_b), 32'd0);
        pulse_clr();
        check_eq("par_err_clr", 32'(err_parity_b), 32'd0);
        send_frame(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("par_good_count", 32'(rx_count_b), 32'd2);
        check_eq("par_good_no_err", 32'(err_parity_b), 32'd0);
        rx_rd_b = 1'b1;
        @(negedge clk);
        rx_rd_b = 1'b0;
        check_eq("par_second_byte", 32'(rx_rdata_b), 32'hA5);

        // reset in the middle of a TX data bit
        push_a(8'h00);
        push_a(8'hF0);
        wait_tx_low(seen);
        check_eq("rst_frame_started", 32'(seen), 32'd1);
        repeat (128) @(negedge clk);
        check_eq("pre_rst_tx_low", 32'(tx_a), 32'd0);
        check_eq("pre_rst_tx_count", 32'(tx_count_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_tx", 32'(tx_a), 32'd1);
        check_eq("post_rst_tx_count", 32'(tx_count_a), 32'd0);
        check_eq("post_rst_tx_busy", 32'(tx_busy_a), 32'd0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check_eq("post_rst_tx_quiet", 32'(tx_a), 32'd1);
        check_eq("post_rst_busy_quiet", 32'(tx_busy_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
